// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct codes of
// the multiply/divide class, FSM state encoding, operation type and a decode
// helper.
package muldiv_pkg;

    localparam int unsigned FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'b011000;
    localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'b011001;
    localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'b011010;
    localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, RUN, SIGN} muldiv_state_t;

    typedef enum logic {MUL, DIV} muldiv_op_t;

    // True for any of the eight multiply/divide-class funct codes.
    function automatic logic is_md_funct(input logic [FUNCT_W-1:0] f);
        logic hit;
        hit = 1'b0;
        case (f)
            FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: one multiply (shift-add) or restoring-divide bit per
// step on unsigned operands held in a shared 2*WIDTH accumulator.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   load_i         capture opa_i/opb_i/div_i and clear the step counter
//   step_i         perform one iteration
//   div_i          1 = divide, 0 = multiply
//   opa_i, opb_i   multiplier/dividend and multiplicand/divisor (magnitudes)
//   acc_o          {hi, lo} = {product high, low} or {remainder, quotient}
//   last_o         the current step is the final (WIDTH-th) one
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 div_i,
    input  logic [WIDTH-1:0]     opa_i,
    input  logic [WIDTH-1:0]     opb_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic                 last_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               div_q;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               qbit;

    // One iteration. Multiply keeps the running sum in the upper half and
    // shifts the multiplier out of the lower half; the carry rides in the
    // extra sum bit. Divide shifts the next dividend bit into the partial
    // remainder and keeps the difference only when it did not borrow.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, opb_q};
        qbit    = ~diff[WIDTH];
        if (div_q) begin
            acc_d = {(qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], qbit};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q <= '0;
            opb_q <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (load_i) begin
            acc_q <= {{WIDTH{1'b0}}, opa_i};
            opb_q <= opb_i;
            cnt_q <= '0;
            div_q <= div_i;
        end else if (step_i) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign acc_o  = acc_q;
    assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit: decodes the multiply/divide funct class,
// runs mult/div in the background, owns HI/LO and stalls only class
// instructions that arrive while it is busy.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   valid, aluop, funct instruction in EX (responds only when aluop == 00)
//   srca, srcb          rs / rt operands
//   flush               abort any in-flight operation
//   stall               hold EX (combinational)
//   result, result_valid mfhi/mflo data (combinational)
//   hi, lo              HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             stall,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_t      state_q;
    muldiv_op_t         op_q;
    logic [WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d;
    logic [WIDTH-1:0]   a_q;
    logic               a_neg_q, b_neg_q, b_zero_q;

    logic               md, accept, start, is_mf, sgn, a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [2*WIDTH-1:0] acc;
    logic               last;
    logic [2*WIDTH-1:0] prod;

    // Decode and handshake.
    assign md     = valid && (aluop == 2'b00) && is_md_funct(funct);
    assign stall  = reset_n && md && (state_q != IDLE);
    assign accept = md && !stall && !flush;
    assign start  = accept && (funct[5:2] == 4'b0110);
    assign is_mf  = (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO);

    assign result_valid = reset_n && accept && is_mf;
    assign result       = result_valid ? ((funct == FUNCT_MFHI) ? hi_q : lo_q)
                                       : '0;

    // Signed ops iterate on magnitudes; funct[0] clear selects signed.
    assign sgn   = ~funct[0];
    assign a_neg = sgn & srca[WIDTH-1];
    assign b_neg = sgn & srcb[WIDTH-1];
    assign a_abs = a_neg ? -srca : srca;
    assign b_abs = b_neg ? -srcb : srcb;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (start),
        .step_i  ((state_q == RUN) && !flush),
        .div_i   (funct[1]),
        .opa_i   (a_abs),
        .opb_i   (b_abs),
        .acc_o   (acc),
        .last_o  (last)
    );

    // Sign fixup of the finished magnitude result.
    always_comb begin
        prod = (a_neg_q ^ b_neg_q) ? -acc : acc;
        hi_d = prod[2*WIDTH-1:WIDTH];
        lo_d = prod[WIDTH-1:0];
        if (op_q == DIV) begin
            if (b_zero_q) begin
                hi_d = a_q;
                lo_d = '1;
            end else begin
                lo_d = (a_neg_q ^ b_neg_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                hi_d = a_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    // Control FSM and HI/LO ownership.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= MUL;
            hi_q     <= '0;
            lo_q     <= '0;
            a_q      <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && (funct == FUNCT_MTHI)) hi_q <= srca;
                    if (accept && (funct == FUNCT_MTLO)) lo_q <= srca;
                    if (start) begin
                        op_q     <= funct[1] ? DIV : MUL;
                        a_q      <= srca;
                        a_neg_q  <= a_neg;
                        b_neg_q  <= b_neg;
                        b_zero_q <= (srcb == '0);
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (flush)     state_q <= IDLE;
                    else if (last) state_q <= SIGN;
                end
                SIGN: begin
                    if (!flush) begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
